// File: rtl/mem_io_bridge_pkg.sv
// Shared constants and helpers for the cpu memory/I-O bridge.
package mem_io_bridge_pkg;

  localparam logic [31:0] IO_BASE        = 32'h0003_0000;
  localparam logic [2:0]  IO_PORT_UART   = 3'h0;
  localparam logic [2:0]  IO_PORT_CLK    = 3'h4;
  localparam int unsigned RAM_ADDR_WIDTH = 17;

  // The I/O window is the top quarter of the 256KB decode space.
  function automatic logic is_io_addr(logic [31:0] addr);
    return addr[17:16] == IO_BASE[17:16];
  endfunction

  // Little-endian byte select from a 32-bit word.
  function automatic logic [7:0] word_byte(logic [31:0] word, logic [1:0] sel);
    logic [7:0] b;
    case (sel)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/mem_io_bridge_byte_fifo.sv
// Byte-wide synchronous FIFO, 2**DEPTH_LOG entries. Push while full is dropped unless a pop
// happens in the same cycle.
module mem_io_bridge_byte_fifo #(
  parameter int unsigned DEPTH_LOG = 3
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               push,
  input  logic [7:0]         wdata,
  input  logic               pop,
  output logic [7:0]         rdata,
  output logic               full,
  output logic               empty,
  output logic [DEPTH_LOG:0] count
);

  localparam int unsigned Depth  = 1 << DEPTH_LOG;
  localparam int unsigned CountW = DEPTH_LOG + 1;
  localparam int unsigned PtrW   = DEPTH_LOG;

  logic [7:0]           mem_q [Depth];
  logic [DEPTH_LOG-1:0] wr_ptr_q, rd_ptr_q;
  logic [DEPTH_LOG:0]   count_q, count_d;
  logic                 do_push, do_pop;

  assign full    = count_q == CountW'(Depth);
  assign empty   = count_q == '0;
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Occupancy next-state.
  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) count_d = count_q + CountW'(1);
    else if (!do_push && do_pop) count_d = count_q - CountW'(1);
  end

  // Pointers and count; pointers wrap naturally modulo depth.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_d;
    end
  end

  // Storage, no reset needed: contents are only visible through valid pointers.
  always_ff @(posedge clk_in) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/mem_io_bridge.sv
// Bridge between the cpu memory port and RAM / UART / clock-counter I/O.
// Optional rx FIFO is enabled by defining MEM_IO_RX_EN.
module mem_io_bridge
  import mem_io_bridge_pkg::*;
#(
  parameter int unsigned TX_DEPTH_LOG = 3,
  parameter int unsigned RX_DEPTH_LOG = 3,
  parameter int unsigned FULL_MARGIN  = 2
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      rdy_in,
  input  logic [31:0]               cpu_a,
  input  logic [7:0]                cpu_dout,
  input  logic                      cpu_wr,
  output logic [7:0]                cpu_din,
  output logic                      io_buffer_full,
  output logic [RAM_ADDR_WIDTH-1:0] ram_a,
  output logic                      ram_we,
  output logic [7:0]                ram_wdata,
  input  logic [7:0]                ram_rdata,
  output logic [7:0]                tx_data,
  output logic                      tx_valid,
  input  logic                      tx_ready,
  input  logic [7:0]                rx_data,
  input  logic                      rx_valid,
  output logic                      program_finished
);

  localparam int unsigned TxCountW = TX_DEPTH_LOG + 1;
  // io_buffer_full asserts once occupancy exceeds depth - margin (free < margin).
  localparam logic [TX_DEPTH_LOG:0] TxFullThresh =
      TxCountW'((1 << TX_DEPTH_LOG) - FULL_MARGIN);

  logic        io, cpu_rd, io_wr;
  logic [2:0]  port;
  logic        tx_push, tx_empty, finish_set, snap_latch, rx_pop;
  logic [7:0]  tx_wdata, rx_byte_d;
  logic [TX_DEPTH_LOG:0] tx_count;
  logic        unused_tx_full;
  logic        unused_cpu_a;

  logic        rd_valid_q, rd_io_q;
  logic [2:0]  rd_sel_q;
  logic [7:0]  rx_byte_q;
  logic [31:0] cnt_q, snap_q;
  logic        finished_q, io_full_q;

  assign unused_cpu_a = ^cpu_a[31:18];

  assign io     = is_io_addr(cpu_a);
  assign port   = cpu_a[2:0];
  assign cpu_rd = ~cpu_wr & rdy_in;
  // I/O writes are dead once the program has signalled stop.
  assign io_wr  = cpu_wr & io & rdy_in & ~finished_q;

  assign ram_a     = cpu_a[RAM_ADDR_WIDTH-1:0];
  assign ram_wdata = cpu_dout;
  assign ram_we    = cpu_wr & ~io & rdy_in;

  // I/O side-effect decode: tx push, stop flag, snapshot latch, rx pop.
  always_comb begin
    tx_push    = 1'b0;
    tx_wdata   = cpu_dout;
    finish_set = 1'b0;
    if (io_wr && port == IO_PORT_UART && cpu_dout != 8'h00) begin
      tx_push = 1'b1;
    end else if (io_wr && port == IO_PORT_CLK) begin
      tx_push    = 1'b1;
      tx_wdata   = 8'h00;
      finish_set = 1'b1;
    end
    snap_latch = cpu_rd & io & (port == IO_PORT_CLK);
    rx_pop     = cpu_rd & io & (port == IO_PORT_UART);
  end

  mem_io_bridge_byte_fifo #(
    .DEPTH_LOG (TX_DEPTH_LOG)
  ) u_tx_fifo (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .push   (tx_push),
    .wdata  (tx_wdata),
    .pop    (tx_ready),
    .rdata  (tx_data),
    .full   (unused_tx_full),
    .empty  (tx_empty),
    .count  (tx_count)
  );

  assign tx_valid = ~tx_empty;

`ifdef MEM_IO_RX_EN
  logic                 rx_empty;
  logic [7:0]           rx_head;
  logic                 unused_rx_full;
  logic [RX_DEPTH_LOG:0] unused_rx_count;

  mem_io_bridge_byte_fifo #(
    .DEPTH_LOG (RX_DEPTH_LOG)
  ) u_rx_fifo (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .push   (rx_valid),
    .wdata  (rx_data),
    .pop    (rx_pop),
    .rdata  (rx_head),
    .full   (unused_rx_full),
    .empty  (rx_empty),
    .count  (unused_rx_count)
  );

  assign rx_byte_d = rx_empty ? 8'h00 : rx_head;
`else
  logic unused_rx;
  assign unused_rx = ^{rx_data, rx_valid, rx_pop, RX_DEPTH_LOG[0]};
  assign rx_byte_d = 8'h00;
`endif

  // Read-response register, cycle counter, snapshot, stop flag and near-full flag.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      rd_valid_q <= 1'b0;
      rd_io_q    <= 1'b0;
      rd_sel_q   <= 3'h0;
      rx_byte_q  <= 8'h00;
      cnt_q      <= 32'h0;
      snap_q     <= 32'h0;
      finished_q <= 1'b0;
      io_full_q  <= 1'b0;
    end else begin
      rd_valid_q <= cpu_rd;
      if (cpu_rd) begin
        rd_io_q  <= io;
        rd_sel_q <= port;
      end
      if (rx_pop) rx_byte_q <= rx_byte_d;
      cnt_q <= cnt_q + 32'd1;
      if (snap_latch) snap_q <= cnt_q;
      if (finish_set) finished_q <= 1'b1;
      io_full_q <= tx_count > TxFullThresh;
    end
  end

  // Read data mux: RAM data arrives now, I/O data was captured at the read.
  always_comb begin
    cpu_din = 8'h00;
    if (rd_valid_q) begin
      if (!rd_io_q) begin
        cpu_din = ram_rdata;
      end else if (rd_sel_q == IO_PORT_UART) begin
        cpu_din = rx_byte_q;
      end else if (rd_sel_q[2]) begin
        cpu_din = word_byte(snap_q, rd_sel_q[1:0]);
      end
    end
  end

  assign io_buffer_full   = io_full_q;
  assign program_finished = finished_q;

endmodule

// File: tb/tb_mem_io_bridge.sv
// Self-checking bench for mem_io_bridge: read and tx scoreboards.
module tb_mem_io_bridge;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        rdy_in = 1'b1;
  logic [31:0] cpu_a = 32'h0;
  logic [7:0]  cpu_dout = 8'h0;
  logic        cpu_wr = 1'b0;
  logic [7:0]  cpu_din;
  logic        io_buffer_full;
  logic [16:0] ram_a;
  logic        ram_we;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata = 8'h0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [7:0]  rx_data = 8'h0;
  logic        rx_valid = 1'b0;
  logic        program_finished;

  int errors = 0;
  int checks = 0;
  logic [7:0] rd_q[$];
  logic [7:0] tx_q[$];
  logic [7:0] exp8;
  logic [7:0] mon_exp;
  logic [31:0] tb_cnt = 32'h0;
  logic [7:0] tb_ram [0:131071];

  always #5 clk_in = ~clk_in;

  mem_io_bridge u_dut (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .rdy_in           (rdy_in),
    .cpu_a            (cpu_a),
    .cpu_dout         (cpu_dout),
    .cpu_wr           (cpu_wr),
    .cpu_din          (cpu_din),
    .io_buffer_full   (io_buffer_full),
    .ram_a            (ram_a),
    .ram_we           (ram_we),
    .ram_wdata        (ram_wdata),
    .ram_rdata        (ram_rdata),
    .tx_data          (tx_data),
    .tx_valid         (tx_valid),
    .tx_ready         (tx_ready),
    .rx_data          (rx_data),
    .rx_valid         (rx_valid),
    .program_finished (program_finished)
  );

  // RAM with one-cycle read latency.
  always @(posedge clk_in) begin
    if (ram_we) tb_ram[ram_a] <= ram_wdata;
    ram_rdata <= tb_ram[ram_a];
  end

  // Reference cycle counter.
  always @(posedge clk_in) tb_cnt <= rst_in ? 32'h0 : tb_cnt + 32'd1;

  // UART side of the tx scoreboard.
  always @(negedge clk_in) begin
    if (!rst_in && tx_valid && tx_ready) begin
      checks++;
      if (tx_q.size() == 0) begin
        errors++;
        $display("FAIL tx_unexpected got %h expected nothing", tx_data);
      end else begin
        mon_exp = tx_q.pop_front();
        if (tx_data !== mon_exp) begin
          errors++;
          $display("FAIL tx_order got %h expected %h", tx_data, mon_exp);
        end
      end
    end
  end

  task automatic cycle();
    @(posedge clk_in);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [7:0] d);
    cpu_a = a; cpu_dout = d; cpu_wr = 1'b1;
    cycle();
    cpu_wr = 1'b0; cpu_a = 32'h0; cpu_dout = 8'h0;
  endtask

  task automatic rd(input logic [31:0] a, input logic [7:0] e);
    cpu_a = a; cpu_wr = 1'b0;
    rd_q.push_back(e);
    cycle();
    cpu_a = 32'h0;
  endtask

  task automatic do_reset();
    rst_in = 1'b1;
    cycle(); cycle();
    rst_in = 1'b0;
    tx_q.delete();
    rd_q.delete();
  endtask

  task automatic test_reset();
    rst_in = 1'b1;
    cycle(); cycle();
    checks++;
    if ({cpu_din, io_buffer_full, ram_we, tx_valid, program_finished} !== 12'h000) begin
      errors++;
      $display("FAIL reset_outputs got din=%h full=%b we=%b txv=%b fin=%b expected all zero",
               cpu_din, io_buffer_full, ram_we, tx_valid, program_finished);
    end
    rst_in = 1'b0;
  endtask

  task automatic test_ram();
    cpu_a = 32'h100; cpu_dout = 8'hAB; cpu_wr = 1'b1;
    #1;
    checks++;
    if (ram_we !== 1'b1 || ram_a !== 17'h100 || ram_wdata !== 8'hAB) begin
      errors++;
      $display("FAIL ram_write got we=%b a=%h d=%h expected 1 00100 ab", ram_we, ram_a, ram_wdata);
    end
    cycle();
    cpu_wr = 1'b0;
    #1;
    checks++;
    if (ram_we !== 1'b0) begin
      errors++;
      $display("FAIL ram_we_pulse got %b expected 0", ram_we);
    end
    rd(32'h100, 8'hAB);
    exp8 = rd_q.pop_front();
    checks++;
    if (cpu_din !== exp8) begin
      errors++;
      $display("FAIL ram_read got %h expected %h", cpu_din, exp8);
    end
  endtask

  task automatic test_tx_filter();
    tx_ready = 1'b1;
    tx_q.push_back(8'h48); wr(32'h30000, 8'h48);
    tx_q.push_back(8'h69); wr(32'h30000, 8'h69);
    wr(32'h30000, 8'h00);
    repeat (6) cycle();
    checks++;
    if (tx_q.size() != 0) begin
      errors++;
      $display("FAIL tx_hi_drain got %0d pending expected 0", tx_q.size());
    end
  endtask

  task automatic test_back_to_back();
    tx_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tx_q.push_back(8'h10 + 8'(i));
      wr(32'h30000, 8'h10 + 8'(i));
    end
    cycle();
    checks++;
    if (io_buffer_full !== 1'b0) begin
      errors++;
      $display("FAIL full_at_6 got %b expected 0", io_buffer_full);
    end
    tx_q.push_back(8'h16); wr(32'h30000, 8'h16);
    cycle();
    checks++;
    if (io_buffer_full !== 1'b1) begin
      errors++;
      $display("FAIL full_at_7 got %b expected 1", io_buffer_full);
    end
    tx_q.push_back(8'h17); wr(32'h30000, 8'h17);
    wr(32'h30000, 8'h18);
    cycle();
    checks++;
    if (io_buffer_full !== 1'b1 || tx_valid !== 1'b1 || tx_data !== 8'h10) begin
      errors++;
      $display("FAIL full_hold got full=%b txv=%b head=%h expected 1 1 10",
               io_buffer_full, tx_valid, tx_data);
    end
    tx_ready = 1'b1;
    repeat (12) cycle();
    checks++;
    if (tx_q.size() != 0 || tx_valid !== 1'b0 || io_buffer_full !== 1'b0) begin
      errors++;
      $display("FAIL fill_drain got pending=%0d txv=%b full=%b expected 0 0 0",
               tx_q.size(), tx_valid, io_buffer_full);
    end
  endtask

  task automatic test_rdy();
    rdy_in = 1'b0;
    cpu_a = 32'h300; cpu_dout = 8'h77; cpu_wr = 1'b1;
    #1;
    checks++;
    if (ram_we !== 1'b0) begin
      errors++;
      $display("FAIL rdy_ram_we got %b expected 0", ram_we);
    end
    cpu_a = 32'h30000;
    cycle();
    cpu_wr = 1'b0; cpu_a = 32'h0; rdy_in = 1'b1;
    cycle();
    checks++;
    if (tx_valid !== 1'b0) begin
      errors++;
      $display("FAIL rdy_io_write got txv=%b expected 0", tx_valid);
    end
  endtask

  task automatic test_clock();
    do_reset();
    for (int i = 0; i < 200 && tb_cnt != 32'd100; i++) cycle();
    rd(32'h30004, 8'h64);
    exp8 = rd_q.pop_front();
    checks++;
    if (cpu_din !== exp8) begin
      errors++;
      $display("FAIL clk_byte0 got %h expected %h", cpu_din, exp8);
    end
    repeat (3) cycle();
    for (int b = 5; b < 8; b++) begin
      rd(32'h30000 + 32'(b), 8'h00);
      exp8 = rd_q.pop_front();
      checks++;
      if (cpu_din !== exp8) begin
        errors++;
        $display("FAIL clk_byte%0d got %h expected %h", b - 4, cpu_din, exp8);
      end
    end
    for (int i = 0; i < 400 && tb_cnt != 32'h12C; i++) cycle();
    rd(32'h30004, 8'h2C);
    exp8 = rd_q.pop_front();
    checks++;
    if (cpu_din !== exp8) begin
      errors++;
      $display("FAIL clk_300_b0 got %h expected %h", cpu_din, exp8);
    end
    cycle();
    rd(32'h30005, 8'h01);
    exp8 = rd_q.pop_front();
    checks++;
    if (cpu_din !== exp8) begin
      errors++;
      $display("FAIL clk_300_b1 got %h expected %h", cpu_din, exp8);
    end
  endtask

  task automatic test_rx();
    logic [7:0] first;
`ifdef MEM_IO_RX_EN
    first = 8'h41;
`else
    first = 8'h00;
`endif
    rx_data = 8'h41; rx_valid = 1'b1;
    cycle();
    rx_valid = 1'b0;
    rd(32'h30000, first);
    exp8 = rd_q.pop_front();
    checks++;
    if (cpu_din !== exp8) begin
      errors++;
      $display("FAIL rx_first got %h expected %h", cpu_din, exp8);
    end
    rd(32'h30000, 8'h00);
    exp8 = rd_q.pop_front();
    checks++;
    if (cpu_din !== exp8) begin
      errors++;
      $display("FAIL rx_empty got %h expected %h", cpu_din, exp8);
    end
  endtask

  task automatic test_finish();
    tx_ready = 1'b1;
    tx_q.push_back(8'h00);
    wr(32'h30004, 8'h55);
    cycle();
    checks++;
    if (program_finished !== 1'b1) begin
      errors++;
      $display("FAIL finish_flag got %b expected 1", program_finished);
    end
    wr(32'h30000, 8'h78);
    wr(32'h400, 8'h5A);
    repeat (4) cycle();
    checks++;
    if (tx_q.size() != 0 || program_finished !== 1'b1) begin
      errors++;
      $display("FAIL finish_tx got pending=%0d fin=%b expected 0 1", tx_q.size(), program_finished);
    end
    rd(32'h400, 8'h5A);
    exp8 = rd_q.pop_front();
    checks++;
    if (cpu_din !== exp8) begin
      errors++;
      $display("FAIL finish_ram got %h expected %h", cpu_din, exp8);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    tx_ready = 1'b0;
    wr(32'h30000, 8'h31);
    wr(32'h30000, 8'h32);
    wr(32'h30004, 8'h01);
    rx_data = 8'h55; rx_valid = 1'b1;
    cpu_a = 32'h30004; cpu_wr = 1'b0;
    cycle();
    rx_valid = 1'b0;
    rst_in = 1'b1;
    cycle();
    rst_in = 1'b0;
    tx_q.delete();
    cpu_a = 32'h0;
    checks++;
    if ({cpu_din, io_buffer_full, tx_valid, program_finished} !== 11'h000) begin
      errors++;
      $display("FAIL reset_mid got din=%h full=%b txv=%b fin=%b expected all zero",
               cpu_din, io_buffer_full, tx_valid, program_finished);
    end
    rd(32'h30000, 8'h00);
    exp8 = rd_q.pop_front();
    checks++;
    if (cpu_din !== exp8) begin
      errors++;
      $display("FAIL reset_mid_rx got %h expected %h", cpu_din, exp8);
    end
    exp8 = tb_cnt[7:0];
    rd(32'h30004, exp8);
    exp8 = rd_q.pop_front();
    checks++;
    if (cpu_din !== exp8) begin
      errors++;
      $display("FAIL reset_mid_cnt got %h expected %h", cpu_din, exp8);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_ram();
    test_tx_filter();
    test_back_to_back();
    test_rdy();
    test_clock();
    test_rx();
    test_finish();
    test_reset_mid();
    repeat (2) cycle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
